mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_if.sv | 22 ++
 rtl/mem_responder.sv | 128 ++++++++++++
 tb/tb_mem_responder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Processor-side memory handshake bundle: request, address/data and the
// registered completion/status signals returned by the responder.
interface mem_responder_if;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] Adr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        MemReady;
   logic        MemErr;
   logic        Busy;

   modport master (
      output MemRead, MemWrite, Adr, WriteData,
      input  ReadData, MemReady, MemErr, Busy
   );

   modport slave (
      input  MemRead, MemWrite, Adr, WriteData,
      output ReadData, MemReady, MemErr, Busy
   );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder with a fixed wait-state count per access,
// error detection for bad addresses/operations and a one-cycle ready pulse.
module mem_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic             clk,
   input  logic             rst,
   mem_responder_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state_reg;
   logic [3:0]    cnt_reg;
   logic [AW-1:0] idx_reg;
   logic [31:0]   wdata_reg;
   logic          rd_reg;
   logic          wr_reg;
   logic          bad_reg;
   logic [31:0]   rdata_reg;
   logic          ready_reg;
   logic          err_reg;

   logic [31:0]   mem [DEPTH];

   logic          req;
   logic          cap_bad;
   logic [AW-1:0] cap_idx;

   logic          fire;
   logic          acc_bad;
   logic          acc_rd;
   logic          acc_wr;
   logic [AW-1:0] acc_idx;
   logic [31:0]   acc_wdata;
   logic          wr_en;
   logic          rd_en;

   assign req     = bus.MemRead | bus.MemWrite;
   assign cap_idx = bus.Adr[AW+1:2];
   assign cap_bad = (bus.Adr[1:0] != 2'b00) | (|bus.Adr[31:AW+2])
                  | (bus.MemRead & bus.MemWrite);

   // With no wait states the access completes on the capture edge itself,
   // so the live inputs feed the storage directly instead of the captured copy.
   generate
      if (LATENCY == 0) begin : g_direct
         assign fire      = ~rst & (state_reg == IDLE) & req;
         assign acc_bad   = cap_bad;
         assign acc_rd    = bus.MemRead;
         assign acc_wr    = bus.MemWrite;
         assign acc_idx   = cap_idx;
         assign acc_wdata = bus.WriteData;
      end else begin : g_wait
         assign fire      = ~rst & (state_reg == WAIT) & (cnt_reg == 4'd1);
         assign acc_bad   = bad_reg;
         assign acc_rd    = rd_reg;
         assign acc_wr    = wr_reg;
         assign acc_idx   = idx_reg;
         assign acc_wdata = wdata_reg;
      end
   endgenerate

   assign wr_en = fire & acc_wr & ~acc_bad;
   assign rd_en = fire & acc_rd & ~acc_bad;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[acc_idx] <= acc_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_reg <= '0;
      end else if (rd_en) begin
         rdata_reg <= mem[acc_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         ready_reg <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         ready_reg <= fire;
         err_reg   <= fire & acc_bad;
         case (state_reg)
            IDLE: begin
               if (req) begin
                  idx_reg   <= cap_idx;
                  wdata_reg <= bus.WriteData;
                  rd_reg    <= bus.MemRead;
                  wr_reg    <= bus.MemWrite;
                  bad_reg   <= cap_bad;
                  if (LATENCY == 0) begin
                     state_reg <= RESP;
                  end else begin
                     state_reg <= WAIT;
                     cnt_reg   <= 4'(LATENCY);
                  end
               end
            end
            WAIT: begin
               cnt_reg <= cnt_reg - 4'd1;
               if (cnt_reg == 4'd1) begin
                  state_reg <= RESP;
               end
            end
            RESP: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.ReadData = rdata_reg;
   assign bus.MemReady = ready_reg;
   assign bus.MemErr   = err_reg;
   assign bus.Busy     = (state_reg != IDLE);
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY=2 and a LATENCY=0 instance checked
// every cycle against a transaction-level model, plus literal expectations.
module tb_mem_responder;
   localparam int DEPTH = 256;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_responder_if bus_a ();
   mem_responder_if bus_b ();

   mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a.slave)
   );

   mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b.slave)
   );

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   int          lat_m [2] = '{2, 0};
   bit [31:0]   mm    [2][DEPTH];
   bit          mk    [2][DEPTH];
   bit          pend  [2];
   bit          resp  [2];
   bit          rdy   [2];
   bit          errm  [2];
   bit          rdk   [2];
   logic [31:0] rdm   [2];
   int          done_at [2];
   bit          crd   [2];
   bit          cwr   [2];
   logic [31:0] cadr  [2];
   logic [31:0] cdat  [2];
   int          cyc = 0;

   task automatic complete(input int k);
      bit e;
      int w;
      e = (cadr[k] % 4 != 0) || (cadr[k] >= 32'(4 * DEPTH)) || (crd[k] && cwr[k]);
      w = int'(cadr[k] >> 2) % DEPTH;
      rdy[k]  = 1'b1;
      errm[k] = e;
      resp[k] = 1'b1;
      pend[k] = 1'b0;
      if (!e && cwr[k]) begin
         mm[k][w] = cdat[k];
         mk[k][w] = 1'b1;
      end
      if (!e && crd[k]) begin
         rdm[k] = mm[k][w];
         rdk[k] = mk[k][w];
      end
   endtask

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         bit          r, w;
         logic [31:0] a, d;
         r = (k == 0) ? bus_a.MemRead   : bus_b.MemRead;
         w = (k == 0) ? bus_a.MemWrite  : bus_b.MemWrite;
         a = (k == 0) ? bus_a.Adr       : bus_b.Adr;
         d = (k == 0) ? bus_a.WriteData : bus_b.WriteData;
         if (rst) begin
            pend[k] = 1'b0; resp[k] = 1'b0; rdy[k] = 1'b0; errm[k] = 1'b0;
            rdm[k]  = '0;   rdk[k]  = 1'b1;
         end else begin
            rdy[k]  = 1'b0;
            errm[k] = 1'b0;
            if (resp[k]) begin
               resp[k] = 1'b0;
            end else if (pend[k]) begin
               if (cyc == done_at[k]) complete(k);
            end else if (r || w) begin
               crd[k] = r; cwr[k] = w; cadr[k] = a; cdat[k] = d;
               done_at[k] = cyc + lat_m[k];
               if (lat_m[k] == 0) complete(k);
               else pend[k] = 1'b1;
            end
         end
      end
      cyc++;
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            logic        r, e, b;
            logic [31:0] d;
            r = (k == 0) ? bus_a.MemReady : bus_b.MemReady;
            e = (k == 0) ? bus_a.MemErr   : bus_b.MemErr;
            b = (k == 0) ? bus_a.Busy     : bus_b.Busy;
            d = (k == 0) ? bus_a.ReadData : bus_b.ReadData;
            check1($sformatf("ready%0d", k), r, rdy[k]);
            check1($sformatf("err%0d", k), e, errm[k]);
            check1($sformatf("busy%0d", k), b, pend[k] | resp[k]);
            if (rdk[k]) check32($sformatf("rdata%0d", k), d, rdm[k]);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input int k, input bit rd, input bit wr, input logic [31:0] adr, input logic [31:0] dat);
      if (k == 0) begin
         bus_a.MemRead = rd; bus_a.MemWrite = wr; bus_a.Adr = adr; bus_a.WriteData = dat;
      end else begin
         bus_b.MemRead = rd; bus_b.MemWrite = wr; bus_b.Adr = adr; bus_b.WriteData = dat;
      end
   endtask

   // Called at a negedge; returns the number of negedges until MemReady was seen.
   task automatic access(input int k, input bit rd, input bit wr, input logic [31:0] adr,
                         input logic [31:0] dat, input bit chg,
                         output logic [31:0] rdata, output logic err, output int lat);
      logic rv;
      drive(k, rd, wr, adr, dat);
      lat = 0;
      rv  = 1'b0;
      while (!rv && lat < 20) begin
         @(negedge clk);
         lat++;
         if (chg && lat == 1) drive(k, rd, wr, adr + 32'd4, ~dat);
         rv = (k == 0) ? bus_a.MemReady : bus_b.MemReady;
      end
      check1("ready_seen", rv, 1'b1);
      rdata = (k == 0) ? bus_a.ReadData : bus_b.ReadData;
      err   = (k == 0) ? bus_a.MemErr   : bus_b.MemErr;
      $display("acc k=%0d rd=%0b wr=%0b adr=%h wdat=%h -> rdata=%h err=%0b lat=%0d",
               k, rd, wr, adr, dat, rdata, err, lat);
      drive(k, 1'b0, 1'b0, adr, dat);
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lt;
      int          pulses;
      logic [7:0]  busy_seq;

      drive(0, 1'b0, 1'b0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check32("reset_rdata", bus_a.ReadData, 32'h0);
      check1("reset_ready", bus_a.MemReady, 1'b0);
      check1("reset_busy", bus_a.Busy, 1'b0);
      rst = 1'b0;

      // write then read, LATENCY=2
      access(0, 0, 1, 32'h10, 32'hDEADBEEF, 0, rd, er, lt);
      check32("wr10_lat", 32'(lt), 32'd3);
      check1("wr10_err", er, 1'b0);
      access(0, 1, 0, 32'h10, 32'h0, 0, rd, er, lt);
      check32("rd10_data", rd, 32'hDEADBEEF);
      check32("rd10_lat", 32'(lt), 32'd3);
      access(0, 0, 1, 32'h20, 32'hAAAA5555, 0, rd, er, lt);
      access(0, 0, 1, 32'h34, 32'h34343434, 0, rd, er, lt);
      access(0, 0, 1, 32'h08, 32'h88888888, 0, rd, er, lt);
      access(0, 0, 1, 32'h00, 32'h01010101, 0, rd, er, lt);

      // misaligned and out-of-range writes
      access(0, 0, 1, 32'h12, 32'hBAD0BAD0, 0, rd, er, lt);
      check1("mis_err", er, 1'b1);
      check32("mis_rdata", rd, 32'hDEADBEEF);
      access(0, 0, 1, 32'h400, 32'hBAD1BAD1, 0, rd, er, lt);
      check1("oor_err", er, 1'b1);
      check32("oor_rdata", rd, 32'hDEADBEEF);

      // simultaneous read and write
      access(0, 1, 1, 32'h08, 32'h77777777, 0, rd, er, lt);
      check1("both_err", er, 1'b1);
      access(0, 1, 0, 32'h08, 32'h0, 0, rd, er, lt);
      check32("rd08_data", rd, 32'h88888888);
      access(0, 1, 0, 32'h10, 32'h0, 0, rd, er, lt);
      check32("rd10_again", rd, 32'hDEADBEEF);
      access(0, 1, 0, 32'h00, 32'h0, 0, rd, er, lt);
      check32("rd00_data", rd, 32'h01010101);

      // reset while in WAIT
      drive(0, 0, 1, 32'h20, 32'h00001234);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drive(0, 0, 0, 32'h20, 32'h0);
      check1("rstwait_busy", bus_a.Busy, 1'b0);
      check1("rstwait_ready", bus_a.MemReady, 1'b0);
      @(negedge clk);

      // reset on the edge that would complete the write; request right after
      drive(0, 0, 1, 32'h20, 32'h00005678);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check1("rstresp_ready", bus_a.MemReady, 1'b0);
      access(0, 1, 0, 32'h20, 32'h0, 0, rd, er, lt);
      check32("rd20_prior", rd, 32'hAAAA5555);
      check32("post_rst_lat", 32'(lt), 32'd3);

      // inputs changed during WAIT
      access(0, 0, 1, 32'h30, 32'hCAFE0001, 1, rd, er, lt);
      access(0, 1, 0, 32'h30, 32'h0, 0, rd, er, lt);
      check32("rd30_data", rd, 32'hCAFE0001);
      access(0, 1, 0, 32'h34, 32'h0, 0, rd, er, lt);
      check32("rd34_data", rd, 32'h34343434);

      // LATENCY=0 instance: back-to-back reads
      access(1, 0, 1, 32'h10, 32'h0B0B0B0B, 0, rd, er, lt);
      check32("b_lat", 32'(lt), 32'd1);
      drive(1, 1, 0, 32'h10, 32'h0);
      pulses   = 0;
      busy_seq = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus_b.MemReady) pulses++;
         busy_seq = {busy_seq[6:0], bus_b.Busy};
      end
      $display("b stream: pulses=%0d busy_seq=%b rdata=%h", pulses, busy_seq, bus_b.ReadData);
      check32("b_pulses", 32'(pulses), 32'd4);
      check32("b_busy_seq", 32'(busy_seq), 32'h000000AA);
      check32("b_rdata", bus_b.ReadData, 32'h0B0B0B0B);
      drive(1, 0, 0, 32'h10, 32'h0);
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
